pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline control unit for the 16-bit RISC core. It stages the hazard-relevant control bits of each instruction through E, M and W. From those it drives the datapath's `forward1`, `forward2`, `flush_e`, `reg_write`, `reg_write_adr`, `mem_write` and `mem_to_reg` inputs. It also generates fetch/decode stall and flush, and sequences interrupt entry and exit from the IO block's `internal_IRQ`.

## Interface
Parameters: none (register address width fixed at 3, 8 registers, no hardwired zero).
- `clock`  in  1  single core clock, all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `valid_d`  in  1  D stage holds a real instruction
- `rs1_d`, `rs2_d`  in  3 each  D-stage source register addresses
- `uses_rs1_d`, `uses_rs2_d`  in  1 each  instruction actually reads rs1/rs2
- `rd_d`  in  3  D-stage destination address
- `reg_write_d`, `mem_write_d`, `mem_to_reg_d`  in  1 each  D-stage decoded controls
- `reti_d`  in  1  D instruction is return-from-interrupt
- `branch_taken_e`  in  1  branch resolved taken in E this cycle
- `irq`  in  1  level interrupt request (`internal_IRQ`)
- `forward1`, `forward2`  out  2 each  0 = reg file, 1 = M ALU result, 2 = W result; 3 never driven
- `stall_f`, `stall_d`  out  1 each  hold PC / hold D register
- `flush_d`  out  1  replace D contents with bubble next edge
- `flush_e`  out  1  replace E contents with bubble next edge
- `mem_write`  out  1  M-stage store enable
- `mem_to_reg`  out  1  W-stage result select
- `reg_write`  out  1  W-stage write enable
- `reg_write_adr`  out  3  W-stage write address
- `irq_ack`  out  1  one-cycle pulse: fetch saves PC of held D instruction, loads vector
- `in_isr`  out  1  interrupt handler active, further IRQs masked

## Operation
- Stage registers: E {valid, rs1, rs2, uses1, uses2, rd, rw, mw, mtr}; M {valid, rd, rw, mw, mtr}; W {valid, rd, rw, mtr}. These advance every cycle.
- A bubble (flush or stall insertion) sets valid=0 and forces rw=mw=0.
- Outputs are gated with valid: `mem_write`=valid_m&mw_m; `reg_write`=valid_w&rw_w; `reg_write_adr`=rd_w; `mem_to_reg`=mtr_w.
- forward1, evaluated combinationally on E fields, priority order:
  - 1 if uses1_e & valid_m & rw_m & !mtr_m & rd_m==rs1_e;
  - else 2 if uses1_e & valid_w & rw_w & rd_w==rs1_e;
  - else 0.
- forward2 is identical on rs2/uses2.
- Load-use: loaduse = valid_d & valid_e & rw_e & mtr_e & ((uses_rs1_d & rs1_d==rd_e) | (uses_rs2_d & rs2_d==rd_e)). It asserts stall_f, stall_d and flush_e for exactly one cycle. The dependent instruction then meets the load in W and forwards with 2.
- Branch: branch_taken_e asserts flush_d and flush_e. Branch overrides loaduse in the same cycle: no stall is asserted.
- Interrupt FSM, states IDLE, DRAIN, VECTOR, ACTIVE:
  - IDLE→DRAIN when irq & valid_d & !branch_taken_e & !loaduse; otherwise recognition is deferred.
  - DRAIN: stall_f=stall_d=flush_e=1. Leave when valid_e=valid_m=valid_w=0, checked on post-edge state.
  - VECTOR (1 cycle): irq_ack=1, flush_d=1, stall_f=0; →ACTIVE.
  - ACTIVE: in_isr=1; irq ignored. valid_d & reti_d & !stall_d & !branch_taken_e → IDLE next edge.
  - reti_d outside ACTIVE is ignored.
- Reset (reset_n=0 at edge): all valid bits 0, FSM IDLE. All outputs then read 0 (forward 0, no stall/flush, irq_ack=0, in_isr=0). Reset mid-DRAIN or mid-ACTIVE abandons the sequence with no ack.

## Timing
- forward*, stall_*, flush_* and the gated outputs are combinational from stage registers and D inputs, valid in the same cycle.
- Stage and FSM updates take effect on the next rising edge.
- Load-use penalty: 1 cycle. Taken-branch penalty: 2 cycles.
- Interrupt entry: recognition at cycle t; DRAIN for t+1..t+3 (E, M, W empty after 3 edges); irq_ack at t+4; the first handler instruction is fetched at t+5.
- W writeback and an E read of the same register in the same cycle resolve by forward=2. The register file is never relied on for write-through.

## Test plan
- ADD r1 then SUB r2,r1,r3 back-to-back → forward1=1 during SUB in E. With one unrelated instruction between them → forward1=2. With two between → forward1=0.
- LOAD r4 then ADD r5,r4,r4 → one cycle with stall_f=stall_d=flush_e=1, then forward1=forward2=2 with mem_to_reg=1.
- Same load-use with branch_taken_e=1 in the stall cycle → flush_d=flush_e=1, stall_f=0, no bubble repeat.
- irq rises with a valid ALU instruction in D → DRAIN for 3 cycles, irq_ack single pulse on the 4th, then in_isr=1. A second irq during ACTIVE has no effect. reti_d → in_isr=0 on the next edge.
- Store of r2 after write of r2 → forward2=1; mem_write high exactly one cycle, in M.
- reset_n=0 during DRAIN → next cycle all outputs 0, FSM IDLE. irq held high then re-enters DRAIN after reset release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and interrupt control for the 16-bit RISC core pipeline.
// Ports: D-stage decode fields, branch/irq in; forwarding, stall/flush, W/M controls, irq_ack/in_isr out.
module pipeline_hazard_ctrl (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       valid_d,
    input  logic [2:0] rs1_d,
    input  logic [2:0] rs2_d,
    input  logic       uses_rs1_d,
    input  logic       uses_rs2_d,
    input  logic [2:0] rd_d,
    input  logic       reg_write_d,
    input  logic       mem_write_d,
    input  logic       mem_to_reg_d,
    input  logic       reti_d,
    input  logic       branch_taken_e,
    input  logic       irq,
    output logic [1:0] forward1,
    output logic [1:0] forward2,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [2:0] reg_write_adr,
    output logic       irq_ack,
    output logic       in_isr
);

    typedef enum logic [1:0] {IDLE, DRAIN, VECTOR, ACTIVE} state_t;

    state_t     state;
    logic       valid_e, uses1_e, uses2_e, rw_e, mw_e, mtr_e;
    logic [2:0] rs1_e, rs2_e, rd_e;
    logic       valid_m, rw_m, mw_m, mtr_m;
    logic [2:0] rd_m;
    logic       valid_w, rw_w, mtr_w;
    logic [2:0] rd_w;

    logic loaduse, drain, vector, take_e, recog, reti_ok;

    assign loaduse = valid_d & valid_e & rw_e & mtr_e &
                     ((uses_rs1_d & (rs1_d == rd_e)) |
                      (uses_rs2_d & (rs2_d == rd_e)));

    assign drain  = (state == DRAIN);
    assign vector = (state == VECTOR);

    // A taken branch squashes the dependent instruction, so no stall.
    assign stall_f = drain | (loaduse & ~branch_taken_e);
    assign stall_d = stall_f;
    assign flush_d = branch_taken_e | vector;
    // The held D instruction must not enter E while vectoring; it is
    // re-fetched from the saved PC after the handler returns.
    assign flush_e = branch_taken_e | loaduse | drain | vector;

    assign take_e  = valid_d & ~flush_e;
    assign recog   = irq & valid_d & ~branch_taken_e & ~loaduse;
    assign reti_ok = valid_d & reti_d & ~stall_d & ~branch_taken_e;

    assign mem_write     = valid_m & mw_m;
    assign reg_write     = valid_w & rw_w;
    assign reg_write_adr = rd_w;
    assign mem_to_reg    = mtr_w;

    always_comb begin
        forward1 = 2'd0;
        forward2 = 2'd0;
        if (uses1_e & valid_m & rw_m & ~mtr_m & (rd_m == rs1_e))
            forward1 = 2'd1;
        else if (uses1_e & valid_w & rw_w & (rd_w == rs1_e))
            forward1 = 2'd2;
        if (uses2_e & valid_m & rw_m & ~mtr_m & (rd_m == rs2_e))
            forward2 = 2'd1;
        else if (uses2_e & valid_w & rw_w & (rd_w == rs2_e))
            forward2 = 2'd2;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_e <= 1'b0; uses1_e <= 1'b0; uses2_e <= 1'b0;
            rw_e    <= 1'b0; mw_e    <= 1'b0; mtr_e   <= 1'b0;
            rs1_e   <= '0;   rs2_e   <= '0;   rd_e    <= '0;
            valid_m <= 1'b0; rw_m    <= 1'b0; mw_m    <= 1'b0;
            mtr_m   <= 1'b0; rd_m    <= '0;
            valid_w <= 1'b0; rw_w    <= 1'b0; mtr_w   <= 1'b0;
            rd_w    <= '0;
            state   <= IDLE;
            irq_ack <= 1'b0;
            in_isr  <= 1'b0;
        end else begin
            // Bubbles clear every field, not just the enables.
            valid_e <= take_e;
            uses1_e <= take_e & uses_rs1_d;
            uses2_e <= take_e & uses_rs2_d;
            rw_e    <= take_e & reg_write_d;
            mw_e    <= take_e & mem_write_d;
            mtr_e   <= take_e & mem_to_reg_d;
            rs1_e   <= take_e ? rs1_d : 3'd0;
            rs2_e   <= take_e ? rs2_d : 3'd0;
            rd_e    <= take_e ? rd_d  : 3'd0;

            valid_m <= valid_e; rw_m <= rw_e; mw_m <= mw_e;
            mtr_m   <= mtr_e;   rd_m <= rd_e;

            valid_w <= valid_m; rw_w <= rw_m; mtr_w <= mtr_m;
            rd_w    <= rd_m;

            unique case (state)
                IDLE: begin
                    if (recog) state <= DRAIN;
                end
                DRAIN: begin
                    // E is being flushed, so after this edge E is empty,
                    // M gets E and W gets M.
                    if (!valid_e && !valid_m) begin
                        state   <= VECTOR;
                        irq_ack <= 1'b1;
                    end
                end
                VECTOR: begin
                    state   <= ACTIVE;
                    irq_ack <= 1'b0;
                    in_isr  <= 1'b1;
                end
                ACTIVE: begin
                    if (reti_ok) begin
                        state  <= IDLE;
                        in_isr <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl.
// Compares every output each cycle against a stage-list reference model.
module tb_pipeline_hazard_ctrl;

    logic       clock, reset_n, valid_d;
    logic [2:0] rs1_d, rs2_d, rd_d;
    logic       uses_rs1_d, uses_rs2_d;
    logic       reg_write_d, mem_write_d, mem_to_reg_d;
    logic       reti_d, branch_taken_e, irq;
    logic [1:0] forward1, forward2;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic       mem_write, mem_to_reg, reg_write;
    logic [2:0] reg_write_adr;
    logic       irq_ack, in_isr;

    pipeline_hazard_ctrl dut (
        .clock(clock), .reset_n(reset_n), .valid_d(valid_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d),
        .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
        .rd_d(rd_d), .reg_write_d(reg_write_d),
        .mem_write_d(mem_write_d), .mem_to_reg_d(mem_to_reg_d),
        .reti_d(reti_d), .branch_taken_e(branch_taken_e), .irq(irq),
        .forward1(forward1), .forward2(forward2),
        .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .reg_write_adr(reg_write_adr),
        .irq_ack(irq_ack), .in_isr(in_isr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       v;
        logic [2:0] rs1, rs2;
        logic       u1, u2;
        logic [2:0] rd;
        logic       rw, mw, mtr;
    } ins_t;

    ins_t me, mm, mwb;
    // 0 idle, 1..3 drain cycles, 4 vector, 5 handler active
    int   ph;
    int   checks, errors;
    logic x_lu, x_stall, x_fe;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fwd_exp(input logic u, input logic [2:0] rs);
        if (u && mm.v && mm.rw && !mm.mtr && mm.rd == rs) return 1;
        if (u && mwb.v && mwb.rw && mwb.rd == rs) return 2;
        return 0;
    endfunction

    function automatic int outs();
        return {forward1, forward2, stall_f, stall_d, flush_d, flush_e,
                mem_write, mem_to_reg, reg_write, reg_write_adr,
                irq_ack, in_isr};
    endfunction

    task automatic sample();
        logic br, drn, vec;
        @(negedge clock);
        br   = branch_taken_e;
        drn  = (ph >= 1 && ph <= 3);
        vec  = (ph == 4);
        x_lu = valid_d && me.v && me.rw && me.mtr &&
               ((uses_rs1_d && rs1_d == me.rd) ||
                (uses_rs2_d && rs2_d == me.rd));
        x_stall = drn || (x_lu && !br);
        x_fe    = br || x_lu || drn || vec;
        chk("forward1", forward1, fwd_exp(me.u1, me.rs1));
        chk("forward2", forward2, fwd_exp(me.u2, me.rs2));
        chk("stall_f", stall_f, x_stall);
        chk("stall_d", stall_d, x_stall);
        chk("flush_d", flush_d, br || vec);
        chk("flush_e", flush_e, x_fe);
        chk("mem_write", mem_write, me.v ? mm.mw && mm.v : mm.v && mm.mw);
        chk("reg_write", reg_write, mwb.v && mwb.rw);
        if (mwb.v) begin
            chk("reg_write_adr", reg_write_adr, mwb.rd);
            chk("mem_to_reg", mem_to_reg, mwb.mtr);
        end
        chk("irq_ack", irq_ack, vec);
        chk("in_isr", in_isr, ph == 5);
    endtask

    task automatic advance();
        ins_t d;
        @(posedge clock);
        if (!reset_n) begin
            me = '0; mm = '0; mwb = '0; ph = 0;
        end else begin
            d = '{valid_d, rs1_d, rs2_d, uses_rs1_d, uses_rs2_d,
                  rd_d, reg_write_d, mem_write_d, mem_to_reg_d};
            mwb = mm;
            mm  = me;
            me  = (x_fe || !valid_d) ? '0 : d;
            case (ph)
                0: if (irq && valid_d && !branch_taken_e && !x_lu) ph = 1;
                5: if (valid_d && reti_d && !x_stall && !branch_taken_e)
                       ph = 0;
                default: ph = ph + 1;
            endcase
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic setd(input logic v, input logic [2:0] a, input logic [2:0] b,
                        input logic u1, input logic u2, input logic [2:0] rd,
                        input logic rw, input logic mw, input logic mtr);
        valid_d = v; rs1_d = a; rs2_d = b;
        uses_rs1_d = u1; uses_rs2_d = u2; rd_d = rd;
        reg_write_d = rw; mem_write_d = mw; mem_to_reg_d = mtr;
        reti_d = 1'b0; branch_taken_e = 1'b0;
    endtask

    task automatic nop();
        setd(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain_pipe();
        irq = 1'b0;
        nop();
        repeat (4) cycle();
    endtask

    task automatic run_fwd(input int gap, input int exp);
        drain_pipe();
        setd(1, 0, 0, 0, 0, 1, 1, 0, 0);
        cycle();
        for (int i = 0; i < gap; i++) begin
            setd(1, 0, 0, 0, 0, 7, 1, 0, 0);
            cycle();
        end
        setd(1, 1, 3, 1, 1, 2, 1, 0, 0);
        cycle();
        nop();
        sample();
        chk($sformatf("fwd_gap%0d", gap), forward1, exp);
        advance();
    endtask

    initial begin
        checks = 0; errors = 0;
        me = '0; mm = '0; mwb = '0; ph = 0;
        x_lu = 0; x_stall = 0; x_fe = 0;
        reset_n = 1'b0; irq = 1'b0;
        nop();
        advance();
        advance();
        sample();
        chk("reset_outs", outs(), 0);
        reset_n = 1'b1;
        advance();

        run_fwd(0, 1);
        run_fwd(1, 2);
        run_fwd(2, 0);

        // load-use
        drain_pipe();
        setd(1, 0, 0, 0, 0, 4, 1, 0, 1);
        cycle();
        setd(1, 4, 4, 1, 1, 5, 1, 0, 0);
        sample();
        chk("lu_stall", {stall_f, stall_d, flush_e}, 7);
        advance();
        sample();
        chk("lu_once", stall_f, 0);
        advance();
        nop();
        sample();
        chk("lu_fwd", {forward1, forward2, mem_to_reg}, 5'b10101);
        advance();

        // load-use overridden by branch
        drain_pipe();
        setd(1, 0, 0, 0, 0, 4, 1, 0, 1);
        cycle();
        setd(1, 4, 4, 1, 1, 5, 1, 0, 0);
        branch_taken_e = 1'b1;
        sample();
        chk("br_flush", {flush_d, flush_e, stall_f}, 3'b110);
        advance();
        nop();
        sample();
        chk("br_no_rep", stall_f, 0);
        advance();

        // store after write
        drain_pipe();
        setd(1, 0, 0, 0, 0, 2, 1, 0, 0);
        cycle();
        setd(1, 3, 2, 1, 1, 0, 0, 1, 0);
        cycle();
        nop();
        sample();
        chk("st_fwd2", forward2, 1);
        chk("st_mw_e", mem_write, 0);
        advance();
        sample();
        chk("st_mw_m", mem_write, 1);
        advance();
        sample();
        chk("st_mw_w", mem_write, 0);
        advance();

        // interrupt entry / exit
        drain_pipe();
        irq = 1'b1;
        setd(1, 1, 2, 1, 1, 3, 1, 0, 0);
        sample();
        chk("irq_rec_isr", in_isr, 0);
        advance();
        for (int k = 1; k <= 3; k++) begin
            sample();
            chk($sformatf("drain%0d_stall", k), stall_f, 1);
            chk($sformatf("drain%0d_ack", k), irq_ack, 0);
            advance();
        end
        sample();
        chk("vec_ack", irq_ack, 1);
        chk("vec_flush_d", flush_d, 1);
        chk("vec_stall_f", stall_f, 0);
        advance();
        setd(1, 4, 4, 0, 0, 5, 1, 0, 0);
        sample();
        chk("act_isr", in_isr, 1);
        chk("act_ack", irq_ack, 0);
        advance();
        sample();
        chk("act_irq_ign", stall_f, 0);
        advance();
        irq = 1'b0;
        setd(1, 0, 0, 0, 0, 6, 1, 0, 0);
        reti_d = 1'b1;
        sample();
        chk("reti_isr_before", in_isr, 1);
        advance();
        nop();
        sample();
        chk("reti_isr_after", in_isr, 0);
        advance();

        // reset in the middle of draining
        drain_pipe();
        irq = 1'b1;
        setd(1, 1, 2, 1, 1, 3, 1, 0, 0);
        cycle();
        sample();
        chk("rd_in_drain", stall_f, 1);
        reset_n = 1'b0;
        advance();
        reset_n = 1'b1;
        sample();
        chk("rd_zero", outs(), 0);
        advance();
        sample();
        chk("rd_reenter", stall_f, 1);
        advance();

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            valid_d        = ($urandom_range(3) != 0);
            rs1_d          = 3'($urandom_range(7));
            rs2_d          = 3'($urandom_range(7));
            rd_d           = 3'($urandom_range(7));
            uses_rs1_d     = 1'($urandom_range(1));
            uses_rs2_d     = 1'($urandom_range(1));
            reg_write_d    = 1'($urandom_range(1));
            mem_write_d    = ($urandom_range(3) == 0);
            mem_to_reg_d   = ($urandom_range(2) == 0);
            reti_d         = ($urandom_range(5) == 0);
            branch_taken_e = ($urandom_range(7) == 0);
            irq            = ($urandom_range(15) == 0);
            reset_n        = ($urandom_range(299) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
